// File: rtl/f1_start_ctrl.sv
// Race-start sequencer: step ticks, light stepping, random hold, reaction timing.
// Define F1_FIXED_DELAY_EN to use a fixed HOLD_TICKS hold instead of the LFSR-derived one.
module f1_start_ctrl #(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned LFSR_W     = 7,
    parameter int unsigned HOLD_MASK  = 7,
    parameter int unsigned HOLD_TICKS = 3,
    parameter int unsigned REACT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trigger,
    input  logic               react,
    output logic               light_step,
    output logic               light_rst,
    output logic [7:0]         lights,
    output logic               busy,
    output logic               result_valid,
    output logic [REACT_W-1:0] reaction_time,
    output logic               jump_start
);

    localparam int unsigned TICK_W   = $clog2(TICK_DIV);
    localparam int unsigned HOLD_MAX = (HOLD_MASK + 1 > HOLD_TICKS) ? HOLD_MASK + 1 : HOLD_TICKS;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

    typedef enum logic [2:0] {StIdle, StSeq, StHold, StGo, StDone} state_e;

    state_e              state_q, state_d;
    logic                trig_q;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [3:0]          step_cnt_q, step_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [REACT_W-1:0]  react_cnt_q, react_cnt_d;
    logic [7:0]          lights_q, lights_d;
    logic                light_step_q, light_step_d;
    logic                light_rst_q, light_rst_d;
    logic                busy_q;
    logic                result_valid_q, result_valid_d;
    logic [REACT_W-1:0]  reaction_time_q, reaction_time_d;
    logic                jump_start_q, jump_start_d;

    logic                trig_rise;
    logic                timing;
    logic                tick;
    logic [3:0]          step_next;
    logic [HOLD_W-1:0]   hold_init;

    assign trig_rise = trigger & ~trig_q;
    assign timing    = (state_q == StSeq) || (state_q == StHold);
    assign tick      = timing && (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    assign step_next = step_cnt_q + 4'd1;

    // Fibonacci LFSR, taps on the top two bits; invertible, so it never reaches 0 from 1
    assign lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-2]};

`ifdef F1_FIXED_DELAY_EN
    assign hold_init = HOLD_W'(HOLD_TICKS);
`else
    assign hold_init = HOLD_W'(lfsr_q & LFSR_W'(HOLD_MASK)) + HOLD_W'(1);
`endif

    always_comb begin
        tick_cnt_d = '0;
        if (timing && (state_d == state_q) && !tick) begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
    end

    always_comb begin
        state_d         = state_q;
        step_cnt_d      = step_cnt_q;
        hold_cnt_d      = hold_cnt_q;
        react_cnt_d     = react_cnt_q;
        lights_d        = lights_q;
        light_step_d    = 1'b0;
        light_rst_d     = 1'b0;
        result_valid_d  = 1'b0;
        reaction_time_d = reaction_time_q;
        jump_start_d    = jump_start_q;

        case (state_q)
            StIdle, StDone: begin
                if (state_q == StIdle) begin
                    lights_d = 8'h00;
                end
                if (trig_rise) begin
                    state_d    = StSeq;
                    step_cnt_d = 4'd0;
                end
            end
            StSeq, StHold: begin
                // An early press beats any tick or transition on the same edge
                if (react) begin
                    state_d         = StDone;
                    lights_d        = 8'h00;
                    light_rst_d     = 1'b1;
                    reaction_time_d = '1;
                    jump_start_d    = 1'b1;
                    result_valid_d  = 1'b1;
                end else if (tick && state_q == StSeq) begin
                    step_cnt_d   = step_next;
                    lights_d     = 8'((9'd1 << step_next) - 9'd1);
                    light_step_d = 1'b1;
                    if (step_cnt_q == 4'd7) begin
                        state_d    = StHold;
                        hold_cnt_d = hold_init;
                    end
                end else if (tick) begin
                    if (hold_cnt_q == HOLD_W'(1)) begin
                        state_d      = StGo;
                        lights_d     = 8'h00;
                        light_step_d = 1'b1;
                        react_cnt_d  = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                    end
                end
            end
            StGo: begin
                if (react) begin
                    state_d         = StDone;
                    reaction_time_d = react_cnt_q;
                    result_valid_d  = 1'b1;
                    jump_start_d    = 1'b0;
                end else if (react_cnt_q != {REACT_W{1'b1}}) begin
                    react_cnt_d = react_cnt_q + REACT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            trig_q          <= 1'b1;
            lfsr_q          <= LFSR_W'(1);
            tick_cnt_q      <= '0;
            step_cnt_q      <= 4'd0;
            hold_cnt_q      <= '0;
            react_cnt_q     <= '0;
            lights_q        <= 8'h00;
            light_step_q    <= 1'b0;
            light_rst_q     <= 1'b0;
            busy_q          <= 1'b0;
            result_valid_q  <= 1'b0;
            reaction_time_q <= '0;
            jump_start_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            trig_q          <= trigger;
            lfsr_q          <= lfsr_d;
            tick_cnt_q      <= tick_cnt_d;
            step_cnt_q      <= step_cnt_d;
            hold_cnt_q      <= hold_cnt_d;
            react_cnt_q     <= react_cnt_d;
            lights_q        <= lights_d;
            light_step_q    <= light_step_d;
            light_rst_q     <= light_rst_d;
            busy_q          <= (state_d == StSeq) || (state_d == StHold) || (state_d == StGo);
            result_valid_q  <= result_valid_d;
            reaction_time_q <= reaction_time_d;
            jump_start_q    <= jump_start_d;
        end
    end

    assign light_step    = light_step_q;
    assign light_rst     = light_rst_q;
    assign lights        = lights_q;
    assign busy          = busy_q;
    assign result_valid  = result_valid_q;
    assign reaction_time = reaction_time_q;
    assign jump_start    = jump_start_q;

endmodule

// File: tb/tb_f1_start_ctrl.sv
// Self-checking bench for f1_start_ctrl: directed race table, corner sequences, random races.
module tb_f1_start_ctrl;

    localparam int TD      = 4;
    localparam int HT      = 2;
    localparam int SEQ_END = 8 * TD;
    localparam int MSEQ    = 0;
    localparam int MHOLD   = 1;
    localparam int MGO     = 2;

    typedef struct {
        int          mode;   // where react lands: SEQ edge, HOLD offset (0 = final tick), GO delay
        int          val;
        bit          glitch; // toggle trigger randomly during the race
        logic [15:0] e_rt;
        logic [3:0]  e_rt4;
        bit          e_js;
    } race_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trigger = 1'b0;
    logic        react = 1'b0;
    logic        light_step, light_rst, busy, result_valid, jump_start;
    logic [7:0]  lights;
    logic [15:0] reaction_time;
    logic        light_step4, light_rst4, busy4, result_valid4, jump_start4;
    logic [7:0]  lights4;
    logic [3:0]  reaction_time4;

    int          vectors = 0;
    int          errors = 0;
    logic [15:0] exp_rt = '0;
    logic [3:0]  exp_rt4 = '0;
    logic        exp_js = 1'b0;
    int          holds[$];
    logic [6:0]  m_lfsr;
    race_t       tbl[9];

    always #5 clk = ~clk;

    f1_start_ctrl #(
        .TICK_DIV(TD), .LFSR_W(7), .HOLD_MASK(7), .HOLD_TICKS(HT), .REACT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .react(react),
        .light_step(light_step), .light_rst(light_rst), .lights(lights), .busy(busy),
        .result_valid(result_valid), .reaction_time(reaction_time), .jump_start(jump_start)
    );

    f1_start_ctrl #(
        .TICK_DIV(TD), .LFSR_W(7), .HOLD_MASK(7), .HOLD_TICKS(HT), .REACT_W(4)
    ) dut4 (
        .clk(clk), .rst(rst), .trigger(trigger), .react(react),
        .light_step(light_step4), .light_rst(light_rst4), .lights(lights4), .busy(busy4),
        .result_valid(result_valid4), .reaction_time(reaction_time4), .jump_start(jump_start4)
    );

    // Reference x^7+x^6+1 sequence: 1 at reset, one step per clock
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 7'd1;
        else     m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_all(input logic [7:0] e_l, input logic e_s, input logic e_r,
                             input logic e_b, input logic e_v);
        chk("lights", 32'(lights), 32'(e_l));
        chk("light_step", 32'(light_step), 32'(e_s));
        chk("light_rst", 32'(light_rst), 32'(e_r));
        chk("busy", 32'(busy), 32'(e_b));
        chk("result_valid", 32'(result_valid), 32'(e_v));
        chk("reaction_time", 32'(reaction_time), 32'(exp_rt));
        chk("jump_start", 32'(jump_start), 32'(exp_js));
        chk("reaction_time_w4", 32'(reaction_time4), 32'(exp_rt4));
        chk("jump_start_w4", 32'(jump_start4), 32'(exp_js));
    endtask

    // DONE/IDLE cycles; react toggles randomly and must be ignored
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            trigger = 1'b0;
            react   = 1'($urandom_range(1, 0));
            @(posedge clk); #1;
            check_all(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        react = 1'b0;
    endtask

    task automatic run_race(input race_t r);
        int         h = 0;
        int         g = 1_000_000;
        int         re;
        int         steps;
        bit         done = 1'b0;
        logic [7:0] e_l;
        re = (r.mode == MSEQ) ? r.val : 1_000_000;
        trigger = 1'b1;
        react   = 1'b0;
        @(posedge clk); #1;
        trigger = 1'b0;
        check_all(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 400 && !done; k++) begin
            if (k == SEQ_END) begin
`ifdef F1_FIXED_DELAY_EN
                h = HT;
`else
                h = int'(m_lfsr & 7'd7) + 1;
`endif
                g = SEQ_END + TD * h;
                if (r.mode == MHOLD) re = (r.val == 0) ? g : SEQ_END + ((r.val - 1) % (TD * h)) + 1;
                else if (r.mode == MGO) re = g + 1 + r.val;
            end
            react   = (k == re);
            trigger = r.glitch ? 1'($urandom_range(1, 0)) : 1'b0;
            @(posedge clk); #1;
            if (k == re) begin
                exp_rt  = r.e_rt;
                exp_rt4 = r.e_rt4;
                exp_js  = r.e_js;
                check_all(8'h00, 1'b0, (k <= g), 1'b0, 1'b1);
                done = 1'b1;
            end else begin
                steps = (k <= SEQ_END) ? k / TD : 8;
                e_l   = (k >= g) ? 8'h00 : 8'((9'd1 << steps) - 9'd1);
                check_all(e_l, ((k <= SEQ_END) && (k % TD == 0)) || (k == g), 1'b0, 1'b1, 1'b0);
                if (light_step && lights == 8'h00 && k > SEQ_END) holds.push_back((k - SEQ_END) / TD);
            end
        end
        react   = 1'b0;
        trigger = 1'b0;
        if (!done) begin
            vectors++;
            errors++;
            $display("FAIL race_timeout: no result within 400 cycles, required a result");
        end
    endtask

    initial begin
        race_t r;
        int    distinct;
        tbl[0] = '{MGO,   5,  1'b0, 16'd5,    4'd5, 1'b0};
        tbl[1] = '{MSEQ,  14, 1'b0, 16'hFFFF, 4'hF, 1'b1};  // lights showing 07
        tbl[2] = '{MHOLD, 0,  1'b0, 16'hFFFF, 4'hF, 1'b1};  // final HOLD tick
        tbl[3] = '{MGO,   0,  1'b0, 16'd0,    4'd0, 1'b0};
        tbl[4] = '{MGO,   20, 1'b0, 16'd20,   4'hF, 1'b0};  // narrow counter saturates
        tbl[5] = '{MSEQ,  32, 1'b0, 16'hFFFF, 4'hF, 1'b1};  // coincides with 8th step
        tbl[6] = '{MHOLD, 3,  1'b0, 16'hFFFF, 4'hF, 1'b1};
        tbl[7] = '{MGO,   15, 1'b1, 16'd15,   4'hF, 1'b0};
        tbl[8] = '{MGO,   14, 1'b0, 16'd14,   4'hE, 1'b0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_all(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        for (int i = 0; i < 9; i++) begin
            run_race(tbl[i]);
            idle(2);
        end

        // Trigger held through reset release must not start a race
        trigger = 1'b1;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        exp_rt = '0; exp_rt4 = '0; exp_js = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_all(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        trigger = 1'b0;
        idle(2);

        // Asynchronous reset mid-race clears everything without a light_rst pulse
        trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        repeat (6) @(posedge clk);
        #4 rst = 1'b1;
        #1 check_all(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        holds.delete();
        for (int i = 0; i < 64; i++) begin
            r.mode   = $urandom_range(3, 0);
            if (r.mode > MGO) r.mode = MGO;
            r.glitch = 1'($urandom_range(1, 0));
            if (r.mode == MSEQ) r.val = $urandom_range(32, 1);
            else if (r.mode == MHOLD) r.val = $urandom_range(32, 0);
            else r.val = $urandom_range(24, 0);
            r.e_js  = (r.mode != MGO);
            r.e_rt  = r.e_js ? 16'hFFFF : 16'(r.val);
            r.e_rt4 = r.e_js ? 4'hF : ((r.val > 15) ? 4'hF : 4'(r.val));
            run_race(r);
            idle($urandom_range(4, 1));
        end

        chk("holds_measured", 32'(holds.size() > 0), 32'd1);
        distinct = 0;
        for (int i = 0; i < holds.size(); i++) begin
            chk("hold_range", 32'(holds[i] >= 1 && holds[i] <= 8), 32'd1);
`ifdef F1_FIXED_DELAY_EN
            chk("hold_fixed", 32'(holds[i]), 32'(HT));
`endif
            if (holds[i] != holds[0]) distinct++;
        end
`ifndef F1_FIXED_DELAY_EN
        chk("hold_distinct", 32'(distinct > 0), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
